// File: rtl/nios_nios2_qsys_0_oci_dct_sequencer.sv
// DCT sequencer: packs 2-bit trace atoms into a 30-bit capture buffer and
// hands each completed (or flushed) buffer downstream as one 34-bit frame.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. atom_ready and frm_valid depend only on registered state, never
// combinationally on the partner's signal. Once frm_valid is raised, the
// frame is held unchanged until frm_ready accepts it.
module nios_nios2_qsys_0_oci_dct_sequencer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             atom_valid,
   input  logic [1:0]       atom,
   output logic             atom_ready,
   input  logic             flush,
   input  logic             end_req,
   output logic             frm_valid,
   output logic [33:0]      frm_data,
   input  logic             frm_ready,
   output logic [29:0]      dct_buffer,
   output logic [3:0]       dct_count,
   output logic             test_ending,
   output logic             test_has_ended,
   output logic [CNT_W-1:0] frames_sent,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      EMIT  = 2'd1,
      ENDED = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic             end_pend, end_pend_nxt;
   logic             ending_nxt, ended_nxt;
   logic [29:0]      buf_nxt, post_buf;
   logic [3:0]       cnt_nxt, post_cnt;
   logic [CNT_W-1:0] sent_nxt;
   logic             accept;

   assign atom_ready = (state == FILL);
   assign accept     = atom_valid & atom_ready;
   assign post_cnt   = dct_count + {3'b000, accept};
   assign frm_data   = {dct_count, dct_buffer};
   assign state_dbg  = state;

   // Buffer contents after writing an accepted atom into the next free slot.
   always_comb begin
      post_buf = dct_buffer;
      for (int k = 0; k < 15; k++) begin
         if (accept && (dct_count == 4'(k))) post_buf[2*k +: 2] = atom;
      end
   end

   // Next-state and next-register decode for the FILL/EMIT/ENDED sequencer.
   always_comb begin
      state_nxt    = state;
      buf_nxt      = dct_buffer;
      cnt_nxt      = dct_count;
      end_pend_nxt = end_pend;
      ending_nxt   = test_ending;
      ended_nxt    = test_has_ended;
      sent_nxt     = frames_sent;
      case (state)
         FILL: begin
            buf_nxt = post_buf;
            cnt_nxt = post_cnt;
            if (end_req && (post_cnt == 4'd0)) begin
               // Nothing to drain: the trace closes immediately.
               state_nxt  = ENDED;
               ending_nxt = 1'b1;
               ended_nxt  = 1'b1;
            end else if ((post_cnt == 4'd15) ||
                         ((flush || end_req) && (post_cnt != 4'd0))) begin
               state_nxt = EMIT;
               if (end_req) begin
                  end_pend_nxt = 1'b1;
                  ending_nxt   = 1'b1;
               end
            end
         end
         EMIT: begin
            if (end_req) begin
               end_pend_nxt = 1'b1;
               ending_nxt   = 1'b1;
            end
            if (frm_ready) begin
               buf_nxt = '0;
               cnt_nxt = '0;
               if (frames_sent != {CNT_W{1'b1}}) sent_nxt = frames_sent + CNT_W'(1);
               // An end request arriving on the handshake edge still closes the trace.
               if (end_pend || end_req) begin
                  state_nxt = ENDED;
                  ended_nxt = 1'b1;
               end else begin
                  state_nxt = FILL;
               end
            end
         end
         ENDED: begin
            ending_nxt = 1'b1;
            ended_nxt  = 1'b1;
         end
         default: state_nxt = FILL;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= FILL;
      else          state <= state_nxt;
   end

   // Datapath and status registers; a frame held at reset is discarded.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dct_buffer     <= '0;
         dct_count      <= '0;
         frm_valid      <= 1'b0;
         end_pend       <= 1'b0;
         test_ending    <= 1'b0;
         test_has_ended <= 1'b0;
         frames_sent    <= '0;
      end else begin
         dct_buffer     <= buf_nxt;
         dct_count      <= cnt_nxt;
         frm_valid      <= (state_nxt == EMIT);
         end_pend       <= end_pend_nxt;
         test_ending    <= ending_nxt;
         test_has_ended <= ended_nxt;
         frames_sent    <= sent_nxt;
      end
   end

endmodule

// File: tb/tb_nios_nios2_qsys_0_oci_dct_sequencer.sv
// Bench for the DCT sequencer: vector table, directed corner sequences,
// randomized run against a queue-based model, and a narrow-counter instance.
module tb_nios_nios2_qsys_0_oci_dct_sequencer;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- main DUT ----------------
   logic        atom_valid = 0, flush = 0, end_req = 0, frm_ready = 0;
   logic [1:0]  atom = 0;
   logic        atom_ready, frm_valid, test_ending, test_has_ended;
   logic [33:0] frm_data;
   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;
   logic [15:0] frames_sent;
   logic [1:0]  state_dbg;

   nios_nios2_qsys_0_oci_dct_sequencer #(.CNT_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .atom_valid(atom_valid), .atom(atom),
      .atom_ready(atom_ready), .flush(flush), .end_req(end_req),
      .frm_valid(frm_valid), .frm_data(frm_data), .frm_ready(frm_ready),
      .dct_buffer(dct_buffer), .dct_count(dct_count), .test_ending(test_ending),
      .test_has_ended(test_has_ended), .frames_sent(frames_sent), .state_dbg(state_dbg)
   );

   // ---------------- saturating-counter DUT ----------------
   logic        s_av = 0, s_fl = 0, s_er = 0, s_rdy = 0;
   logic [1:0]  s_a = 0;
   logic        s_ar, s_fv, s_te, s_the;
   logic [33:0] s_data;
   logic [29:0] s_buf;
   logic [3:0]  s_cnt;
   logic [1:0]  s_fs;
   logic [1:0]  s_state;

   nios_nios2_qsys_0_oci_dct_sequencer #(.CNT_W(2)) dut_sat (
      .clk(clk), .reset_n(reset_n), .atom_valid(s_av), .atom(s_a),
      .atom_ready(s_ar), .flush(s_fl), .end_req(s_er),
      .frm_valid(s_fv), .frm_data(s_data), .frm_ready(s_rdy),
      .dct_buffer(s_buf), .dct_count(s_cnt), .test_ending(s_te),
      .test_has_ended(s_the), .frames_sent(s_fs), .state_dbg(s_state)
   );

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_err = 0;
   logic [33:0] exp_q[$];
   bit sb_on = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Frames leaving the DUT are matched in order against frames the model formed.
   always @(negedge clk) begin
      if (sb_on && reset_n && frm_valid && frm_ready) begin
         if (exp_q.size() == 0) chk("sb_unexpected_frame", frm_data, 34'h0);
         else chk("sb_frame", frm_data, exp_q.pop_front());
      end
   end

   // ---------------- reference model ----------------
   int m_slots[$];
   bit m_hold, m_pend, m_ending, m_ended;
   int m_frames;

   function automatic logic [29:0] pack(input int slots[$]);
      logic [29:0] v;
      v = '0;
      foreach (slots[k]) v = v | (30'(slots[k]) << (2 * k));
      return v;
   endfunction

   task automatic model_reset();
      m_slots.delete();
      m_hold = 0; m_pend = 0; m_ending = 0; m_ended = 0; m_frames = 0;
      exp_q.delete();
   endtask

   // Advances the model by one clock using the inputs currently driven.
   task automatic model_step();
      if (m_ended) return;
      if (!m_hold) begin
         if (atom_valid) m_slots.push_back(int'(atom));
         if (m_slots.size() == 15 || ((flush || end_req) && m_slots.size() > 0)) begin
            m_hold = 1;
            if (end_req) begin m_pend = 1; m_ending = 1; end
            exp_q.push_back({4'(m_slots.size()), pack(m_slots)});
         end else if (end_req) begin
            m_ending = 1; m_ended = 1;
         end
      end else begin
         if (end_req) begin m_pend = 1; m_ending = 1; end
         if (frm_ready) begin
            if (m_frames < 65535) m_frames++;
            m_slots.delete();
            m_hold = 0;
            if (m_pend) m_ended = 1;
         end
      end
   endtask

   task automatic model_check();
      chk("rnd_count",   64'(dct_count),      64'(m_slots.size()));
      chk("rnd_buffer",  64'(dct_buffer),     64'(pack(m_slots)));
      chk("rnd_fvalid",  64'(frm_valid),      64'(m_hold));
      chk("rnd_aready",  64'(atom_ready),     64'(!m_hold && !m_ended));
      chk("rnd_ending",  64'(test_ending),    64'(m_ending));
      chk("rnd_ended",   64'(test_has_ended), 64'(m_ended));
      chk("rnd_frames",  64'(frames_sent),    64'(m_frames));
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      atom_valid = 0; atom = 0; flush = 0; end_req = 0; frm_ready = 0;
      s_av = 0; s_a = 0; s_fl = 0; s_er = 0; s_rdy = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset_n = 0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1;
      model_reset();
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_count"},  64'(dct_count),      64'd0);
      chk({tag, "_buffer"}, 64'(dct_buffer),     64'd0);
      chk({tag, "_fvalid"}, 64'(frm_valid),      64'd0);
      chk({tag, "_aready"}, 64'(atom_ready),     64'd1);
      chk({tag, "_ending"}, 64'(test_ending),    64'd0);
      chk({tag, "_ended"},  64'(test_has_ended), 64'd0);
      chk({tag, "_frames"}, 64'(frames_sent),    64'd0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        av;
      logic [1:0]  a;
      logic        fl;
      logic        er;
      logic        rdy;
      logic [3:0]  e_cnt;
      logic        e_fv;
      logic        e_ar;
      logic [29:0] e_buf;
      logic [15:0] e_fs;
   } vec_t;

   vec_t vecs[13];

   initial begin
      logic [33:0] bp_frame;
      int bp_slots[$];

      // Partial flush, empty flush, then atom coinciding with flush at count 4.
      vecs[0]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1, 30'h3,   16'd0};
      vecs[1]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b1, 30'hF,   16'd0};
      vecs[2]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1, 30'h1F,  16'd0};
      vecs[3]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 30'h1F,  16'd0};
      vecs[4]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 30'h0,   16'd1};
      vecs[5]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 30'h0,   16'd1};
      vecs[6]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1, 30'h0,   16'd1};
      vecs[7]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b1, 30'h4,   16'd1};
      vecs[8]  = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1, 30'h24,  16'd1};
      vecs[9]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1, 30'hE4,  16'd1};
      vecs[10] = '{1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0, 30'h2E4, 16'd1};
      vecs[11] = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 30'h0,   16'd2};
      vecs[12] = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1, 30'h1,   16'd2};

      // Reset state, sampled while reset is held and after release.
      idle_inputs();
      reset_n = 0;
      #12;
      chk_reset_state("rst_hold");
      @(posedge clk); #1 reset_n = 1;
      step();
      chk_reset_state("rst_rel");

      // Table-driven vectors.
      foreach (vecs[i]) begin
         atom_valid = vecs[i].av; atom = vecs[i].a; flush = vecs[i].fl;
         end_req = vecs[i].er; frm_ready = vecs[i].rdy;
         step();
         chk($sformatf("vec%0d_count", i),  64'(dct_count),   64'(vecs[i].e_cnt));
         chk($sformatf("vec%0d_fvalid", i), 64'(frm_valid),   64'(vecs[i].e_fv));
         chk($sformatf("vec%0d_aready", i), 64'(atom_ready),  64'(vecs[i].e_ar));
         chk($sformatf("vec%0d_data", i),   64'(frm_data),    64'({vecs[i].e_cnt, vecs[i].e_buf}));
         chk($sformatf("vec%0d_frames", i), 64'(frames_sent), 64'(vecs[i].e_fs));
      end

      // Full-frame fill with atoms k mod 4.
      do_reset();
      frm_ready = 1;
      for (int k = 0; k < 15; k++) begin
         atom_valid = 1; atom = 2'(k % 4);
         step();
      end
      chk("full_fvalid", 64'(frm_valid), 64'd1);
      chk("full_data",   64'(frm_data),  64'({4'hF, 30'h24E4E4E4}));
      atom_valid = 0;
      step();
      chk("full_count_after",  64'(dct_count),   64'd0);
      chk("full_frames_after", 64'(frames_sent), 64'd1);
      chk("full_fvalid_after", 64'(frm_valid),   64'd0);

      // Backpressure: frame held while atoms keep being offered.
      frm_ready = 0;
      bp_slots.delete();
      for (int k = 0; k < 15; k++) begin
         atom_valid = 1; atom = 2'($urandom_range(0, 3));
         bp_slots.push_back(int'(atom));
         step();
      end
      bp_frame = {4'hF, pack(bp_slots)};
      chk("bp_fvalid", 64'(frm_valid), 64'd1);
      for (int c = 0; c < 10; c++) begin
         atom_valid = 1; atom = 2'($urandom_range(0, 3));
         step();
         chk("bp_aready_low", 64'(atom_ready), 64'd0);
         chk("bp_data_held",  64'(frm_data),   64'(bp_frame));
      end
      frm_ready = 1; atom_valid = 1; atom = 2'd2;
      step();
      chk("bp_frames_release", 64'(frames_sent), 64'd2);
      chk("bp_fvalid_release", 64'(frm_valid),   64'd0);
      chk("bp_count_release",  64'(dct_count),   64'd0);
      step();
      chk("bp_next_count", 64'(dct_count),  64'd1);
      chk("bp_next_slot0", 64'(dct_buffer), 64'd2);
      chk("bp_frames_one", 64'(frames_sent), 64'd2);

      // End-of-test while a frame is held downstream.
      atom = 2'd1;
      step();
      atom_valid = 0; flush = 1; frm_ready = 0;
      step();
      chk("end1_fvalid", 64'(frm_valid), 64'd1);
      flush = 0; end_req = 1;
      step();
      chk("end1_ending",     64'(test_ending),    64'd1);
      chk("end1_not_ended",  64'(test_has_ended), 64'd0);
      chk("end1_fvalid_hold", 64'(frm_valid),     64'd1);
      end_req = 0; frm_ready = 1;
      step();
      chk("end1_ended",   64'(test_has_ended), 64'd1);
      chk("end1_fvalid0", 64'(frm_valid),      64'd0);
      chk("end1_frames",  64'(frames_sent),    64'd3);
      atom_valid = 1; flush = 1;
      repeat (3) step();
      chk("end1_aready_low", 64'(atom_ready), 64'd0);
      chk("end1_count_zero", 64'(dct_count),  64'd0);
      chk("end1_no_frame",   64'(frm_valid),  64'd0);

      // End-of-test with an empty buffer.
      do_reset();
      end_req = 1;
      step();
      chk("end2_ending", 64'(test_ending),    64'd1);
      chk("end2_ended",  64'(test_has_ended), 64'd1);
      chk("end2_fvalid", 64'(frm_valid),      64'd0);
      chk("end2_aready", 64'(atom_ready),     64'd0);
      end_req = 0; atom_valid = 1; flush = 1; frm_ready = 1;
      step();
      chk("end2_fvalid_still", 64'(frm_valid),   64'd0);
      chk("end2_count_still",  64'(dct_count),   64'd0);
      chk("end2_frames_still", 64'(frames_sent), 64'd0);

      // Asynchronous reset while a 7-atom frame is held.
      do_reset();
      for (int k = 0; k < 7; k++) begin
         atom_valid = 1; atom = 2'(k % 4);
         step();
      end
      atom_valid = 0; flush = 1;
      step();
      flush = 0;
      chk("mid_fvalid", 64'(frm_valid), 64'd1);
      chk("mid_count",  64'(dct_count), 64'd7);
      #2 reset_n = 0;
      #1;
      chk_reset_state("mid_async");
      @(posedge clk); #1 reset_n = 1;
      step();
      chk_reset_state("mid_after");

      // Randomized run against the model.
      do_reset();
      sb_on = 1;
      for (int i = 0; i < 3000; i++) begin
         atom_valid = ($urandom_range(0, 3) != 0);
         atom       = 2'($urandom_range(0, 3));
         flush      = ($urandom_range(0, 9) == 0);
         end_req    = ($urandom_range(0, 249) == 0);
         frm_ready  = ($urandom_range(0, 3) != 0);
         model_step();
         step();
         model_check();
         if (m_ended && $urandom_range(0, 7) == 0) do_reset();
      end
      sb_on = 0;

      // Saturating frame counter on the 2-bit instance.
      do_reset();
      for (int f = 0; f < 5; f++) begin
         s_av = 1; s_a = 2'(f % 4); s_fl = 1; s_rdy = 1;
         step();
         chk($sformatf("sat_fvalid%0d", f), 64'(s_fv), 64'd1);
         s_av = 0; s_fl = 0;
         step();
         chk($sformatf("sat_frames%0d", f), 64'(s_fs), 64'((f + 1 > 3) ? 3 : f + 1));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
